// File: rtl/ps2_byte_receiver.sv
// PS/2 device-to-host byte receiver, fully in the CLK100MHZ domain.
// The PS/2 clock is synchronised, glitch-filtered and edge-detected; frames are checked for odd parity and stop bit.
module ps2_byte_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       CLK100MHZ,
    input  logic       CPU_RESETN,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    output logic       busy
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t          state_q, state_d;
    logic            clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic            filt_q, filt_d;
    logic [7:0]      fcnt_q, fcnt_d;
    logic            fall_q, fall_d;
    logic [2:0]      bitcnt_q, bitcnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            rx_err_q, rx_err_d;
    logic            timeout, frame_ok, stop_fall;

    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            state_q    <= IDLE;
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            filt_q     <= 1'b1;
            fcnt_q     <= '0;
            fall_q     <= 1'b0;
            bitcnt_q   <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tcnt_q     <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_s1_q   <= PS2_CLK;
            clk_s2_q   <= clk_s1_q;
            dat_s1_q   <= PS2_DATA;
            dat_s2_q   <= dat_s1_q;
            filt_q     <= filt_d;
            fcnt_q     <= fcnt_d;
            fall_q     <= fall_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tcnt_q     <= tcnt_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_err_q   <= rx_err_d;
        end
    end

    // Timeout only fires on a cycle without a fall, so it never collides with the stop-bit check.
    assign timeout   = (state_q != IDLE) && !fall_q && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
    assign stop_fall = (state_q == STOP) && fall_q;
    assign frame_ok  = (^{shift_q, par_q}) && dat_s2_q;

    // Filter, edge detect and frame datapath
    always_comb begin
        filt_d    = filt_q;
        fcnt_d    = '0;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == 8'(FILTER_LEN - 1)) filt_d = ~filt_q;
            else                              fcnt_d = fcnt_q + 8'd1;
        end
        fall_d     = filt_q & ~filt_d;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_err_d   = timeout;
        if (state_q == IDLE || fall_q || timeout) tcnt_d = '0;
        else                                      tcnt_d = tcnt_q + 1'b1;
        if (fall_q) begin
            case (state_q)
                IDLE:   bitcnt_d = '0;
                DATA: begin
                    shift_d  = {dat_s2_q, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                end
                PARITY: par_d = dat_s2_q;
                default: ;
            endcase
        end
        if (stop_fall) begin
            if (frame_ok) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                rx_err_d   = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = IDLE;
        end else if (fall_q) begin
            case (state_q)
                IDLE:    if (!dat_s2_q) state_d = DATA;
                DATA:    if (bitcnt_q == 3'd7) state_d = PARITY;
                PARITY:  state_d = STOP;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy     = (state_q != IDLE);
        rx_data  = rx_data_q;
        rx_valid = rx_valid_q;
        rx_err   = rx_err_q;
    end
endmodule
